// File: rtl/multicycle_core_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_core_pkg
// Shared definitions for the multicycle RV32I-subset core: FSM state encoding,
// major opcode constants, ALU operation and immediate-format enums, plus the
// funct3/funct7 -> ALU operation decoder shared by R- and I-type execution.
// -----------------------------------------------------------------------------
package multicycle_core_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEMADDR,
        MEMRD,
        MEMWR,
        WB_ALU,
        WB_MEM,
        BRANCH,
        JAL,
        HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_type_t;

    // Legality is decided on the opcode alone; funct3 values outside the
    // supported set fall back to an add.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic sub_bit);
        alu_op_t op;
        case (funct3)
            3'b000:  op = sub_bit ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// -----------------------------------------------------------------------------
// regfile
// 32 x XLEN integer register file, two combinational read ports, one write
// port. x0 is hard-wired to zero: writes to it are dropped and reads return 0.
// No reset: contents survive a core reset.
// Ports:
//   clk                      clock
//   i_raddr_a / o_rdata_a    read port A
//   i_raddr_b / o_rdata_b    read port B
//   i_we, i_waddr, i_wdata   write port
// -----------------------------------------------------------------------------
module regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic [4:0]      i_raddr_a,
    output logic [XLEN-1:0] o_rdata_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_b,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_mem [0:31];

    always_ff @(posedge clk) begin
        if (i_we && (i_waddr != 5'd0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads are combinational so DECODE can latch operands in its own cycle.
    assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
// Multicycle RV32I subset (add/sub/and/or/slt, addi/andi/ori/slti, lw, sw,
// beq, jal) sharing one memory port for fetch and data. Illegal opcodes halt.
// Ports:
//   clk        clock
//   reset      synchronous, active-low
//   mem_req    memory request valid
//   mem_we     1 = store, 0 = read (valid with mem_req)
//   mem_addr   word-aligned byte address
//   mem_wdata  store data
//   mem_rdata  read data, valid with mem_ready
//   mem_ready  completes the current request
//   pc         architectural PC register
//   halted     sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc,
    output logic            halted
);

    state_t          r_state;
    logic [XLEN-1:0] r_pc, r_ir, r_old_pc, r_a, r_b, r_alu_out, r_mdr;
    logic            r_halted;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    imm_type_t       w_imm_type;
    logic [XLEN-1:0] w_imm;
    alu_op_t         w_alu_op;
    logic [XLEN-1:0] w_alu_b, w_alu_res;
    logic [XLEN-1:0] w_pc_target;
    logic            w_rf_we;
    logic [XLEN-1:0] w_rf_wdata;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];

    regfile #(.XLEN(XLEN)) u_regfile (
        .clk       (clk),
        .i_raddr_a (r_ir[19:15]),
        .o_rdata_a (w_rs1_data),
        .i_raddr_b (r_ir[24:20]),
        .o_rdata_b (w_rs2_data),
        .i_we      (w_rf_we),
        .i_waddr   (r_ir[11:7]),
        .i_wdata   (w_rf_wdata)
    );

    // Immediate format follows the opcode of the latched instruction.
    always_comb begin
        w_imm_type = IMM_I;
        case (w_opcode)
            OP_STORE:  w_imm_type = IMM_S;
            OP_BRANCH: w_imm_type = IMM_B;
            OP_JAL:    w_imm_type = IMM_J;
            default:   w_imm_type = IMM_I;
        endcase
    end

    always_comb begin
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        case (w_imm_type)
            IMM_S:   w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            IMM_B:   w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            IMM_J:   w_imm = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            default: w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        endcase
    end

    // ALU: register operand B only for R-type; every other user (I-type,
    // address generation) adds the immediate.
    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_b  = w_imm;
        if (r_state == EXEC_R) begin
            w_alu_op = alu_decode(w_funct3, r_ir[30]);
            w_alu_b  = r_b;
        end else if (r_state == EXEC_I) begin
            w_alu_op = alu_decode(w_funct3, 1'b0);
        end
        w_alu_res = r_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_AND: w_alu_res = r_a & w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
            default: w_alu_res = r_a + w_alu_b;
        endcase
    end

    // Branch and jump targets are relative to the instruction's own address.
    assign w_pc_target = r_old_pc + w_imm;

    assign w_rf_we = (r_state == WB_ALU) || (r_state == WB_MEM) || (r_state == JAL);
    always_comb begin
        w_rf_wdata = r_alu_out;
        if (r_state == WB_MEM) begin
            w_rf_wdata = r_mdr;
        end else if (r_state == JAL) begin
            w_rf_wdata = r_old_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_halted  <= 1'b0;
            r_ir      <= '0;
            r_old_pc  <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_ir     <= mem_rdata;
                        r_old_pc <= r_pc;
                        r_pc     <= r_pc + XLEN'(4);
                        r_state  <= DECODE;
                    end
                end
                DECODE: begin
                    r_a <= w_rs1_data;
                    r_b <= w_rs2_data;
                    case (w_opcode)
                        OP_R:               r_state <= EXEC_R;
                        OP_I:               r_state <= EXEC_I;
                        OP_LOAD, OP_STORE:  r_state <= MEMADDR;
                        OP_BRANCH:          r_state <= BRANCH;
                        OP_JAL:             r_state <= JAL;
                        default: begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: begin
                    r_alu_out <= w_alu_res;
                    r_state   <= WB_ALU;
                end
                MEMADDR: begin
                    r_alu_out <= w_alu_res;
                    r_state   <= (w_opcode == OP_STORE) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    if (mem_ready) begin
                        r_mdr   <= mem_rdata;
                        r_state <= WB_MEM;
                    end
                end
                MEMWR: begin
                    if (mem_ready) begin
                        r_state <= FETCH;
                    end
                end
                WB_ALU, WB_MEM: r_state <= FETCH;
                BRANCH: begin
                    if (r_a == r_b) begin
                        r_pc <= w_pc_target;
                    end
                    r_state <= FETCH;
                end
                JAL: begin
                    r_pc    <= w_pc_target;
                    r_state <= FETCH;
                end
                HALT:    r_state <= HALT;
                default: r_state <= HALT;
            endcase
        end
    end

    // Gating with reset drops any request as soon as reset is asserted, so a
    // transaction in progress is abandoned rather than completed.
    assign mem_req   = reset && ((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR));
    assign mem_we    = (r_state == MEMWR);
    assign mem_addr  = (r_state == FETCH) ? r_pc : r_alu_out;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_core
// Directed and random programs run from a bench-owned memory. An
// instruction-set model interprets each program up front and produces the
// ordered list of memory transactions and per-instruction cycle costs that
// the core must reproduce.
// -----------------------------------------------------------------------------
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, halted;
    logic [31:0] mem_addr, mem_wdata, pc;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .halted    (halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory seen by the core, and the model's private copy.
    logic [31:0] mem  [0:127];
    logic [31:0] mmem [0:127];
    logic [31:0] xr   [0:31];

    // Expected transactions: kind 0 = fetch, 1 = load, 2 = store.
    int          exp_kind [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_cost [$];

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] m;
        m = 12'(imm);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [12:0] m;
        m = 13'(imm);
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'b000, m[4:1], m[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] m;
        m = 21'(imm);
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic void wr_reg(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) xr[rd] = v;
    endfunction

    // Instruction-set interpreter: executes the program in mmem from address 0
    // and records what the memory port must see.
    task automatic model_run();
        logic [31:0] p, ins, a, b, r, ea, imm_i, imm_s, imm_b, imm_j, nxt;
        int          cost;
        bit          done;
        p = 32'h0;
        done = 1'b0;
        exp_kind.delete(); exp_addr.delete(); exp_data.delete(); exp_cost.delete();
        for (int n = 0; n < 300 && !done; n++) begin
            ins = mmem[p[8:2]];
            exp_kind.push_back(0); exp_addr.push_back(p); exp_data.push_back(32'h0);
            a = xr[ins[19:15]];
            b = xr[ins[24:20]];
            imm_i = {{20{ins[31]}}, ins[31:20]};
            imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            nxt = p + 32'd4;
            cost = 0;
            case (ins[6:0])
                7'h33, 7'h13: begin
                    if (ins[6:0] == 7'h13) b = imm_i;
                    case (ins[14:12])
                        3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        3'd6:    r = a | b;
                        3'd7:    r = a & b;
                        default: r = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
                    endcase
                    wr_reg(ins[11:7], r);
                    cost = 4;
                end
                7'h03: begin
                    ea = a + imm_i;
                    exp_kind.push_back(1); exp_addr.push_back(ea); exp_data.push_back(32'h0);
                    wr_reg(ins[11:7], mmem[ea[8:2]]);
                    cost = 5;
                end
                7'h23: begin
                    ea = a + imm_s;
                    exp_kind.push_back(2); exp_addr.push_back(ea); exp_data.push_back(b);
                    mmem[ea[8:2]] = b;
                    cost = 4;
                end
                7'h63: begin
                    if (a == b) nxt = p + imm_b;
                    cost = 3;
                end
                7'h6F: begin
                    wr_reg(ins[11:7], p + 32'd4);
                    nxt = p + imm_j;
                    cost = 3;
                end
                default: done = 1'b1;
            endcase
            exp_cost.push_back(cost);
            p = nxt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // mode 0: zero-wait memory; 1: random wait states; 2: first fetch stalled
    // three cycles, zero-wait afterwards.
    task automatic run_prog(input int mode, input bit chk_pc8);
        int          k, last_fetch, waits, prev_cost, stall_left, kind;
        bit          first, pend, rdy;
        logic [31:0] pa, pw, ea;
        logic        pwe;
        k = 0; last_fetch = 0; waits = 0; prev_cost = 0;
        stall_left = (mode == 2) ? 3 : 0;
        first = 1'b1; pend = 1'b0; pa = '0; pw = '0; pwe = 1'b0;
        do_reset();
        while (exp_kind.size() > 0 && k < 5000) begin
            #1;
            if (chk_pc8 && k == 8) check_eq("pc_after_8", pc, 32'h8);
            if (pend) begin
                check_eq("hold_req", {31'd0, mem_req}, 32'd1);
                check_eq("hold_addr", mem_addr, pa);
                check_eq("hold_we", {31'd0, mem_we}, {31'd0, pwe});
                check_eq("hold_wdata", mem_wdata, pw);
            end
            pend = 1'b0;
            if (mem_req) begin
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) != 0);
                    default: rdy = (stall_left == 0);
                endcase
                mem_ready = rdy;
                mem_rdata = $urandom;
                if (!rdy) begin
                    if (stall_left > 0) stall_left--;
                    waits++;
                    pend = 1'b1; pa = mem_addr; pw = mem_wdata; pwe = mem_we;
                end else begin
                    kind = exp_kind.pop_front();
                    ea = exp_addr.pop_front();
                    pw = exp_data.pop_front();
                    $display("txn k=%0d kind=%0d addr=%h we=%0b wdata=%h", k, kind, mem_addr, mem_we, mem_wdata);
                    check_eq("txn_addr", mem_addr, ea);
                    check_eq("txn_we", {31'd0, mem_we}, (kind == 2) ? 32'd1 : 32'd0);
                    if (kind == 2) begin
                        check_eq("txn_wdata", mem_wdata, pw);
                        mem[mem_addr[8:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[8:2]];
                    end
                    if (kind == 0) begin
                        check_eq("fetch_pc", pc, ea);
                        if (!first) check_eq("instr_cycles", 32'(k - last_fetch), 32'(prev_cost + waits));
                        first = 1'b0;
                        last_fetch = k;
                        waits = 0;
                        prev_cost = exp_cost.pop_front();
                    end
                end
            end else begin
                mem_ready = ($urandom_range(0, 1) == 1);
                mem_rdata = $urandom;
            end
            @(negedge clk);
            k++;
        end
        check_eq("no_timeout", {31'd0, (exp_kind.size() == 0)}, 32'd1);
        // The last fetch was the illegal opcode: DECODE now, HALT next cycle.
        #1;
        check_eq("halted_in_decode", {31'd0, halted}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("halted_set", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = ($urandom_range(0, 1) == 1);
            check_eq("halt_no_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            #1;
        end
        check_eq("halted_sticky", {31'd0, halted}, 32'd1);
    endtask

    task automatic gen_random();
        int a, sel, rd, rs1, rs2, f3;
        int f3tab [4];
        f3tab = '{0, 2, 6, 7};
        a = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int r = 1; r < 8; r++) begin
            mem[a] = enc_i(int'($urandom_range(0, 4095)), 0, 0, r, 7'h13);
            a++;
        end
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 8));
            rd  = int'($urandom_range(0, 7));
            rs1 = int'($urandom_range(0, 7));
            rs2 = int'($urandom_range(0, 7));
            f3  = f3tab[$urandom_range(0, 3)];
            case (sel)
                0, 1, 2: mem[a] = enc_r((f3 == 0 && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
                3, 4:    mem[a] = enc_i(int'($urandom_range(0, 4095)), rs1, f3, rd, 7'h13);
                5:       mem[a] = enc_i(256 + 4 * int'($urandom_range(0, 31)), 0, 2, rd, 7'h03);
                6:       mem[a] = enc_s(256 + 4 * int'($urandom_range(0, 31)), rs2, 0);
                7:       mem[a] = enc_b(8, ($urandom_range(0, 1) == 1) ? rs1 : rs2, rs1);
                default: mem[a] = enc_j(8, rd);
            endcase
            a++;
        end
        for (int r = 1; r < 8; r++) begin
            mem[a] = enc_s(384 + 4 * r, r, 0);
            a++;
        end
        mem[a] = 32'h0000007F;
    endtask

    task automatic load_and_model();
        for (int i = 0; i < 128; i++) mmem[i] = mem[i];
        model_run();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) xr[i] = 32'h0;
        for (int i = 0; i < 128; i++) mem[i] = (i < 64) ? 32'h0 : $urandom;

        // Reset aborts a fetch that is still waiting for memory.
        do_reset();
        #1;
        check_eq("first_fetch_req", {31'd0, mem_req}, 32'd1);
        check_eq("first_fetch_addr", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        do_reset();

        // addi/add, sw/lw round trip through address 0, x0 writes, rd==rs1.
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = enc_i(5, 0, 0, 1, 7'h13);
        mem[1]  = enc_r(0, 1, 1, 0, 2);
        mem[2]  = enc_s(0, 2, 0);
        mem[3]  = enc_i(0, 0, 2, 3, 7'h03);
        mem[4]  = enc_i(7, 0, 0, 0, 7'h13);
        mem[5]  = enc_r(0, 0, 0, 0, 4);
        mem[6]  = enc_s(256, 3, 0);
        mem[7]  = enc_s(260, 4, 0);
        mem[8]  = enc_i(1, 1, 0, 1, 7'h13);
        mem[9]  = enc_s(264, 1, 0);
        mem[10] = 32'h0000007F;
        load_and_model();
        run_prog(0, 1'b1);
        check_eq("sw_addr0_data", mem[0], 32'd10);
        check_eq("x3_after_lw", mem[64], 32'd10);
        check_eq("x4_from_x0", mem[65], 32'd0);
        check_eq("x1_rd_eq_rs1", mem[66], 32'd6);

        // Backward beq and jal link/target, first fetch stalled.
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = enc_j(16, 0);
        mem[4]  = enc_b(-4, 0, 0);
        mem[3]  = enc_j(20, 0);
        mem[8]  = enc_j(8, 1);
        mem[10] = enc_s(256, 1, 0);
        mem[11] = 32'h0000007F;
        load_and_model();
        run_prog(2, 1'b0);
        check_eq("jal_link", mem[64], 32'h24);

        for (int r = 0; r < 6; r++) begin
            gen_random();
            load_and_model();
            run_prog(r % 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
